// File: rtl/multi_channel_sampler.sv
// Multi-channel audio output sampler: frame FIFO, per-period frame release,
// and one first-order sigma-delta PWM modulator per channel.
module multi_channel_sampler #(
    parameter int CLK_DIV    = 2500,
    parameter int CODE_WIDTH = 10,
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [NUM_CH*CODE_WIDTH-1:0]    in_data,
    output logic                            in_ready,
    input  logic                            hold_last,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            sample_tick,
    output logic [15:0]                     underflow_cnt,
    output logic [NUM_CH-1:0]               pwm_out
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0]      LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [CODE_WIDTH-1:0] MIDSCALE = {1'b1, {(CODE_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]             r_cnt;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [LVL_W-1:0]             r_level;
    logic [15:0]                  r_uflow_cnt;
    logic [NUM_CH*CODE_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [CODE_WIDTH-1:0]        r_code [NUM_CH];
    logic [CODE_WIDTH:0]          r_acc [NUM_CH];

    logic w_tick;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_uflow;

    assign w_tick  = (r_cnt == CNT_LAST);
    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_push  = in_valid && !w_full;
    // Emptiness is judged before this cycle's push: no bypass into the codes.
    assign w_pop   = w_tick && !w_empty;
    assign w_uflow = w_tick && w_empty;

    assign in_ready      = !w_full;
    assign fifo_level    = r_level;
    assign sample_tick   = w_tick;
    assign underflow_cnt = r_uflow_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_uflow_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
                r_uflow_cnt <= r_uflow_cnt + 1'b1;
            end
        end
    end

    // The accumulator drops its carry each cycle; the carry itself is the PWM bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_code[k] <= MIDSCALE;
                r_acc[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_acc[k] <= {1'b0, r_acc[k][CODE_WIDTH-1:0]} + {1'b0, r_code[k]};
                if (w_pop) begin
                    r_code[k] <= r_mem[r_rd_ptr][k*CODE_WIDTH +: CODE_WIDTH];
                end else if (w_uflow && !hold_last) begin
                    r_code[k] <= MIDSCALE;
                end
            end
        end
    end

    always_comb begin
        pwm_out = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pwm_out[k] = r_acc[k][CODE_WIDTH];
        end
    end

endmodule
